// File: rtl/vector_mem_pkg.sv
// Shared definitions for the MEM-stage vector memory paths.
//   VEC_LANES / VEC_DATA_WIDTH / VEC_ADDR_WIDTH : default vector geometry
//   vst_state_t : store-sequencer states (IDLE, STORE, DONE)
//   vec_t       : one packed vector register, lane 0 in the low bits
package vector_mem_pkg;

  localparam int VEC_LANES      = 16;
  localparam int VEC_DATA_WIDTH = 16;
  localparam int VEC_ADDR_WIDTH = 19;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STORE = 2'd1,
    DONE  = 2'd2
  } vst_state_t;

  typedef logic [VEC_LANES-1:0][VEC_DATA_WIDTH-1:0] vec_t;

endpackage

// File: rtl/vector_snapshot_buf.sv
// Capture register for the vector being stored, with a lane read mux.
// Optional build macro: VSTORE_MASK_EN (also captures per-lane write mask).
// Ports:
//   clk      : clock, rising edge
//   load     : capture vec_in (and mask_in) on this edge
//   vec_in   : source vector
//   mask_in  : lane write mask (VSTORE_MASK_EN only)
//   rd_idx   : lane to present on rd_data / rd_mask
//   rd_data  : captured element at rd_idx
//   rd_mask  : captured mask bit at rd_idx (VSTORE_MASK_EN only)
module vector_snapshot_buf
  import vector_mem_pkg::*;
#(
  parameter int DATA_WIDTH = VEC_DATA_WIDTH,
  parameter int LANES      = VEC_LANES,
  parameter int IDX_W      = $clog2(LANES)
) (
  input  logic                             clk,
  input  logic                             load,
  input  logic [LANES-1:0][DATA_WIDTH-1:0] vec_in,
`ifdef VSTORE_MASK_EN
  input  logic [LANES-1:0]                 mask_in,
  output logic                             rd_mask,
`endif
  input  logic [IDX_W-1:0]                 rd_idx,
  output logic [DATA_WIDTH-1:0]            rd_data
);

  // Pure data storage: no reset, contents only matter after a load.
  logic [LANES-1:0][DATA_WIDTH-1:0] vec_q;

  always_ff @(posedge clk) begin
    if (load) vec_q <= vec_in;
  end

  assign rd_data = vec_q[rd_idx];

`ifdef VSTORE_MASK_EN
  logic [LANES-1:0] mask_q;

  always_ff @(posedge clk) begin
    if (load) mask_q <= mask_in;
  end

  assign rd_mask = mask_q[rd_idx];
`endif

endmodule

// File: rtl/vector_store_handler.sv
// Vector store sequencer for the MEM stage: writes a LANES-element vector to
// data memory one element per cycle at base+i, stalling the pipeline until
// the last element has been written.
// Optional build macro: VSTORE_MASK_EN (adds LaneMask; masked lanes still
// take a cycle but do not assert MemWriteEn).
// Ports:
//   clk, rst        : clock (rising edge), synchronous active-high reset
//   Vectorop        : MEM-stage op is a vector op
//   WriteEn         : op is a store (start = Vectorop & WriteEn)
//   Address         : base word address, sampled at start
//   VectorWrite     : source vector, sampled at start
//   LaneMask        : per-lane write enable, sampled at start (VSTORE_MASK_EN)
//   MemWriteEn      : memory write strobe (registered)
//   Out_Address     : memory write address (registered)
//   MemoryDataWrite : memory write data (registered)
//   BlockPipeSt     : stall request (combinational)
//   StoreDone       : one-cycle completion pulse (registered)
module vector_store_handler
  import vector_mem_pkg::*;
#(
  parameter int DATA_WIDTH = VEC_DATA_WIDTH,
  parameter int LANES      = VEC_LANES,
  parameter int ADDR_WIDTH = VEC_ADDR_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             Vectorop,
  input  logic                             WriteEn,
  input  logic [ADDR_WIDTH-1:0]            Address,
  input  logic [LANES-1:0][DATA_WIDTH-1:0] VectorWrite,
`ifdef VSTORE_MASK_EN
  input  logic [LANES-1:0]                 LaneMask,
`endif
  output logic                             MemWriteEn,
  output logic [ADDR_WIDTH-1:0]            Out_Address,
  output logic [DATA_WIDTH-1:0]            MemoryDataWrite,
  output logic                             BlockPipeSt,
  output logic                             StoreDone
);

  localparam int IDX_W = $clog2(LANES);

  vst_state_t            state;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      nxt_idx;
  logic [ADDR_WIDTH-1:0] base_q;
  logic                  start;
  logic                  accept;
  logic [DATA_WIDTH-1:0] buf_data;
  logic                  lane0_we;
  logic                  nxt_we;

  assign start   = Vectorop & WriteEn;
  assign accept  = (state == IDLE) && start;
  assign nxt_idx = idx + IDX_W'(1);

  // Stall is raised combinationally in the accepting cycle so the op that
  // started the store is held in MEM, then for every STORE cycle.
  assign BlockPipeSt = accept || (state == STORE);

  // Outputs are registered one lane ahead: the accepting edge launches lane 0
  // straight from the inputs, each STORE edge launches lane idx+1 from the
  // snapshot, so the buffer is read at nxt_idx.
  vector_snapshot_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .LANES      (LANES),
    .IDX_W      (IDX_W)
  ) u_snap (
    .clk     (clk),
    .load    (accept),
    .vec_in  (VectorWrite),
`ifdef VSTORE_MASK_EN
    .mask_in (LaneMask),
    .rd_mask (nxt_we),
`endif
    .rd_idx  (nxt_idx),
    .rd_data (buf_data)
  );

`ifdef VSTORE_MASK_EN
  assign lane0_we = LaneMask[0];
`else
  assign lane0_we = 1'b1;
  assign nxt_we   = 1'b1;
`endif

  // Base address is data: captured on acceptance, never reset.
  always_ff @(posedge clk) begin
    if (accept) base_q <= Address;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      idx             <= '0;
      MemWriteEn      <= 1'b0;
      Out_Address     <= '0;
      MemoryDataWrite <= '0;
      StoreDone       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          StoreDone  <= 1'b0;
          MemWriteEn <= 1'b0;
          if (start) begin
            state           <= STORE;
            idx             <= '0;
            MemWriteEn      <= lane0_we;
            Out_Address     <= Address;
            MemoryDataWrite <= VectorWrite[0];
          end
        end
        STORE: begin
          // LANES is a power of two, so the last lane is idx all-ones and
          // nxt_idx wraps back to zero on the way out.
          idx <= nxt_idx;
          if (&idx) begin
            state      <= DONE;
            MemWriteEn <= 1'b0;
            StoreDone  <= 1'b1;
          end else begin
            MemWriteEn      <= nxt_we;
            Out_Address     <= base_q + ADDR_WIDTH'(nxt_idx);
            MemoryDataWrite <= buf_data;
          end
        end
        DONE: begin
          StoreDone <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state      <= IDLE;
          MemWriteEn <= 1'b0;
          StoreDone  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vector_store_handler.sv
// Directed bench for vector_store_handler: table of store transactions plus
// hand-written sequences for reset behaviour and ignored load ops.
// Build macro VSTORE_MASK_EN enables the LaneMask connection and mask checks.
module tb_vector_store_handler;
  import vector_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        Vectorop;
  logic        WriteEn;
  logic [18:0] Address;
  vec_t        VectorWrite;
`ifdef VSTORE_MASK_EN
  logic [15:0] LaneMask;
`endif
  logic        MemWriteEn;
  logic [18:0] Out_Address;
  logic [15:0] MemoryDataWrite;
  logic        BlockPipeSt;
  logic        StoreDone;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vector_store_handler dut (
    .clk             (clk),
    .rst             (rst),
    .Vectorop        (Vectorop),
    .WriteEn         (WriteEn),
    .Address         (Address),
    .VectorWrite     (VectorWrite),
`ifdef VSTORE_MASK_EN
    .LaneMask        (LaneMask),
`endif
    .MemWriteEn      (MemWriteEn),
    .Out_Address     (Out_Address),
    .MemoryDataWrite (MemoryDataWrite),
    .BlockPipeSt     (BlockPipeSt),
    .StoreDone       (StoreDone)
  );

  typedef struct {
    string       name;
    logic [18:0] addr;
    logic [15:0] dbase;
    logic [15:0] mask;
    logic [18:0] exp_last;  // hand-computed address of lane 15
    bit          scramble;  // change inputs during STORE
    bit          hold;      // keep start asserted after acceptance
  } rec_t;

  rec_t tbl[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_store(input rec_t r);
    logic [15:0] em;
    logic [18:0] ea;
`ifdef VSTORE_MASK_EN
    em = r.mask;
    LaneMask = r.mask;
`else
    em = 16'hFFFF;
`endif
    Vectorop = 1'b1;
    WriteEn  = 1'b1;
    Address  = r.addr;
    for (int j = 0; j < 16; j++) VectorWrite[j] = r.dbase + 16'(j);
    #1;
    chk($sformatf("%s_accept_stall", r.name), 32'(BlockPipeSt), 32'd1);
    tick();
    if (!r.hold) begin
      Vectorop = 1'b0;
      WriteEn  = 1'b0;
    end
    for (int i = 0; i < 16; i++) begin
      ea = r.addr + 19'(i);
      chk($sformatf("%s_we%0d", r.name, i), 32'(MemWriteEn), 32'(em[i]));
      chk($sformatf("%s_addr%0d", r.name, i), 32'(Out_Address), 32'(ea));
      chk($sformatf("%s_data%0d", r.name, i), 32'(MemoryDataWrite), 32'(r.dbase + 16'(i)));
      chk($sformatf("%s_stall%0d", r.name, i), 32'(BlockPipeSt), 32'd1);
      chk($sformatf("%s_nodone%0d", r.name, i), 32'(StoreDone), 32'd0);
      if (i == 15) chk($sformatf("%s_lastaddr", r.name), 32'(Out_Address), 32'(r.exp_last));
      if (r.scramble) begin
        Address = r.addr ^ 19'h2AAAA ^ 19'(i);
        for (int j = 0; j < 16; j++) VectorWrite[j] = 16'hDEAD ^ 16'(i * 17 + j);
      end
      tick();
    end
    chk($sformatf("%s_done", r.name), 32'(StoreDone), 32'd1);
    chk($sformatf("%s_done_we", r.name), 32'(MemWriteEn), 32'd0);
    chk($sformatf("%s_done_stall", r.name), 32'(BlockPipeSt), 32'd0);
    tick();
    chk($sformatf("%s_idle_done", r.name), 32'(StoreDone), 32'd0);
    chk($sformatf("%s_idle_we", r.name), 32'(MemWriteEn), 32'd0);
    chk($sformatf("%s_idle_stall", r.name), 32'(BlockPipeSt), 32'(r.hold));
  endtask

  initial begin
    tbl[0] = '{"lane",       19'h00100, 16'hA000, 16'hFFFF, 19'h0010F, 1'b0, 1'b0};
    tbl[1] = '{"wrap",       19'h7FFF8, 16'h5000, 16'hFFFF, 19'h00007, 1'b0, 1'b0};
    tbl[2] = '{"busy",       19'h01230, 16'hC000, 16'hFFFF, 19'h0123F, 1'b1, 1'b1};
    tbl[3] = '{"after_busy", 19'h02000, 16'h3000, 16'hFFFF, 19'h0200F, 1'b0, 1'b0};
    tbl[4] = '{"mask",       19'h03050, 16'h9000, 16'h00F1, 19'h0305F, 1'b0, 1'b0};

    rst         = 1'b1;
    Vectorop    = 1'b0;
    WriteEn     = 1'b0;
    Address     = '0;
    VectorWrite = '0;
`ifdef VSTORE_MASK_EN
    LaneMask    = 16'hFFFF;
`endif
    tick();
    tick();
    chk("rst_we",    32'(MemWriteEn),      32'd0);
    chk("rst_addr",  32'(Out_Address),     32'd0);
    chk("rst_data",  32'(MemoryDataWrite), 32'd0);
    chk("rst_done",  32'(StoreDone),       32'd0);
    chk("rst_stall", 32'(BlockPipeSt),     32'd0);

    // rst and start on the same edge: the start is dropped
    Vectorop = 1'b1;
    WriteEn  = 1'b1;
    Address  = 19'h00500;
    tick();
    rst      = 1'b0;
    Vectorop = 1'b0;
    WriteEn  = 1'b0;
    #1;
    chk("rststart_we",    32'(MemWriteEn),  32'd0);
    chk("rststart_stall", 32'(BlockPipeSt), 32'd0);
    tick();
    chk("rststart_we2",   32'(MemWriteEn),  32'd0);
    chk("rststart_done",  32'(StoreDone),   32'd0);

    for (int t = 0; t < 5; t++) do_store(tbl[t]);

    // reset after the 5th write of a store
    Vectorop = 1'b1;
    WriteEn  = 1'b1;
    Address  = 19'h00400;
    for (int j = 0; j < 16; j++) VectorWrite[j] = 16'h7000 + 16'(j);
`ifdef VSTORE_MASK_EN
    LaneMask = 16'hFFFF;
`endif
    tick();
    Vectorop = 1'b0;
    WriteEn  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("midrst_we%0d", i),   32'(MemWriteEn),  32'd1);
      chk($sformatf("midrst_addr%0d", i), 32'(Out_Address), 32'h400 + 32'(i));
      if (i < 4) tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_we",    32'(MemWriteEn),      32'd0);
    chk("midrst_addr",  32'(Out_Address),     32'd0);
    chk("midrst_data",  32'(MemoryDataWrite), 32'd0);
    chk("midrst_done",  32'(StoreDone),       32'd0);
    chk("midrst_stall", 32'(BlockPipeSt),     32'd0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("postrst_we%0d", i),   32'(MemWriteEn), 32'd0);
      chk($sformatf("postrst_done%0d", i), 32'(StoreDone),  32'd0);
    end

    // load op (Vectorop without WriteEn) is never accepted
    Vectorop = 1'b1;
    WriteEn  = 1'b0;
    Address  = 19'h00777;
    for (int i = 0; i < 20; i++) begin
      #1;
      chk($sformatf("load_we%0d", i),    32'(MemWriteEn),  32'd0);
      chk($sformatf("load_stall%0d", i), 32'(BlockPipeSt), 32'd0);
      chk($sformatf("load_done%0d", i),  32'(StoreDone),   32'd0);
      tick();
    end
    Vectorop = 1'b0;
    WriteEn  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("wronly_stall%0d", i), 32'(BlockPipeSt), 32'd0);
      tick();
      chk($sformatf("wronly_we%0d", i),    32'(MemWriteEn),  32'd0);
    end
    WriteEn = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
